// File: rtl/audio_sample_feeder.sv
// rtl/audio_sample_feeder.sv - sample FIFO feeding a word serializer under play control
// A RELEASE state drops the enable for one cycle between words so the serializer can clear its done flag.
module audio_sample_feeder #(
    parameter int WORD_LENGTH = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic                          play_i,
    input  logic [WORD_LENGTH-1:0]        wr_data_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    output logic [WORD_LENGTH-1:0]        ser_data_o,
    output logic                          ser_enable_o,
    input  logic                          ser_done_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o,
    output logic                          underrun_o,
    output logic [7:0]                    underrun_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   full_q, full_d;
    logic [WORD_LENGTH-1:0] ser_data_q, ser_data_d;
    logic                   ser_enable_q, ser_enable_d;
    logic                   busy_q, busy_d;
    logic                   underrun_q, underrun_d;
    logic [7:0]             underrun_count_q, underrun_count_d;
    logic [WORD_LENGTH-1:0] mem_q [FIFO_DEPTH];
    logic                   push, pop, can_pop;

    always_comb begin
        push             = wr_valid_i && !full_q;
        can_pop          = play_i && (count_q != '0);
        pop              = 1'b0;
        state_d          = state_q;
        ser_data_d       = ser_data_q;
        underrun_d       = 1'b0;
        underrun_count_d = underrun_count_q;
        case (state_q)
            ST_IDLE: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    ser_data_d = mem_q[rd_ptr_q];
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ser_done_i) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    ser_data_d = mem_q[rd_ptr_q];
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                    if (play_i) begin
                        underrun_d = 1'b1;
                        if (underrun_count_q != 8'hFF) underrun_count_d = underrun_count_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Pointers are AW bits wide, so wrap modulo FIFO_DEPTH comes for free.
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        count_d      = count_q + CW'(push) - CW'(pop);
        full_d       = (count_d == CW'(FIFO_DEPTH));
        ser_enable_d = (state_d == ST_RUN);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q          <= ST_IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            full_q           <= 1'b0;
            ser_data_q       <= '0;
            ser_enable_q     <= 1'b0;
            busy_q           <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            full_q           <= full_d;
            ser_data_q       <= ser_data_d;
            ser_enable_q     <= ser_enable_d;
            busy_q           <= busy_d;
            underrun_q       <= underrun_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign wr_ready_o       = !full_q;
    assign ser_data_o       = ser_data_q;
    assign ser_enable_o     = ser_enable_q;
    assign fifo_count_o     = count_q;
    assign busy_o           = busy_q;
    assign underrun_o       = underrun_q;
    assign underrun_count_o = underrun_count_q;
endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb/tb_audio_sample_feeder.sv - scoreboard bench for audio_sample_feeder
module tb_audio_sample_feeder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] ser_data;
    logic        ser_enable;
    logic        ser_done = 1'b0;
    logic [4:0]  fifo_count;
    logic        busy, underrun;
    logic [7:0]  underrun_count;

    int total = 0;
    int bad = 0;
    int words_started = 0;
    int underrun_seen = 0;
    int low_cycles = 0;
    int run_cnt = 0;
    bit check_gap = 0;
    bit prev_en = 0;
    logic [15:0] cur_word = '0;
    logic [15:0] exp_q[$];

    audio_sample_feeder #(.WORD_LENGTH(16), .FIFO_DEPTH(16)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .play_i(play),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .ser_data_o(ser_data), .ser_enable_o(ser_enable), .ser_done_i(ser_done),
        .fifo_count_o(fifo_count), .busy_o(busy), .underrun_o(underrun),
        .underrun_count_o(underrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serializer model: raises done after three enabled cycles, clears it once enable drops.
    initial begin
        forever begin
            @(negedge clk);
            if (ser_enable) begin
                run_cnt++;
                if (run_cnt >= 3) ser_done = 1'b1;
            end else begin
                run_cnt = 0;
                ser_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each word start, checks hold stability and gaps.
    initial begin
        forever begin
            @(negedge clk);
            if (underrun) underrun_seen++;
            if (ser_enable && !prev_en) begin
                if (check_gap) check("gap", low_cycles, 1);
                low_cycles = 0;
                words_started++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL word: got 0x%0h want none (queue empty)", ser_data);
                end else begin
                    cur_word = exp_q.pop_front();
                    if (ser_data !== cur_word) begin
                        bad++;
                        $display("FAIL word: got 0x%0h want 0x%0h", ser_data, cur_word);
                    end
                end
            end else if (ser_enable) begin
                check("hold", ser_data, cur_word);
            end else begin
                low_cycles++;
            end
            prev_en = ser_enable;
        end
    end

    task automatic push_word(input logic [15:0] d, input bit accept);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        check("wr_ready", wr_ready, accept);
        if (accept) exp_q.push_back(d);
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_words(input int target);
        int n = 0;
        while (words_started < target && n < 300) begin
            @(negedge clk);
            #1 n++;
        end
        if (words_started < target) begin
            bad++;
            $display("FAIL wait_words: got %0d want %0d", words_started, target);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            #1 n++;
        end
        check("idle", busy, 0);
    endtask

    task automatic play_until(input int target);
        @(negedge clk);
        play = 1'b1;
        wait_words(target);
        play = 1'b0;
        wait_idle();
    endtask

    initial begin
        int base;
        int n;
        #12;
        check("rst_enable", ser_enable, 0);
        check("rst_data", ser_data, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_underrun_cnt", underrun_count, 0);
        check("rst_wr_ready", wr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word: latency of one cycle, then underrun when the FIFO runs dry.
        push_word(16'hA5C3, 1);
        @(negedge clk);
        play = 1'b1;
        @(negedge clk);
        #1;
        check("latency_en", ser_enable, 1);
        check("latency_data", ser_data, 16'hA5C3);
        wait_idle();
        check("single_underrun_pulses", underrun_seen, 1);
        check("single_underrun_cnt", underrun_count, 1);
        play = 1'b0;

        // Streaming four words back to back.
        for (int i = 1; i <= 4; i++) push_word(16'(i), 1);
        base = words_started;
        @(negedge clk);
        play = 1'b1;
        wait_words(base + 1);
        check_gap = 1;
        wait_words(base + 4);
        play = 1'b0;
        check_gap = 0;
        wait_idle();
        check("stream_underrun", underrun_count, 1);

        // Push on the same edge as a RELEASE pop with three words left.
        for (int i = 0; i < 4; i++) push_word(16'h1100 + 16'(i), 1);
        base = words_started;
        @(negedge clk);
        play = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1 n++;
        end while (!(busy && !ser_enable) && n < 50);
        check("sim_count_before", fifo_count, 3);
        wr_valid = 1'b1;
        wr_data  = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        check("sim_count_after", fifo_count, 3);
        wait_words(base + 5);
        play = 1'b0;
        wait_idle();

        // Stop mid-word: word completes, no underrun, remaining words kept.
        for (int i = 0; i < 3; i++) push_word(16'h2200 + 16'(i), 1);
        base = words_started;
        play_until(base + 1);
        check("stop_underrun", underrun_count, 1);
        check("stop_count", fifo_count, 2);
        play_until(base + 3);

        // Full and wrap.
        for (int i = 0; i < 16; i++) push_word(16'h3300 + 16'(i), 1);
        push_word(16'hDEAD, 0);
        check("full_count", fifo_count, 16);
        base = words_started;
        play_until(base + 16);
        check("drain_count", fifo_count, 0);
        for (int i = 0; i < 5; i++) push_word(16'h4400 + 16'(i), 1);
        play_until(base + 21);
        check("wrap_count", fifo_count, 0);

        // Asynchronous reset mid-RUN.
        push_word(16'h5501, 1);
        push_word(16'h5502, 1);
        base = words_started;
        @(negedge clk);
        play = 1'b1;
        wait_words(base + 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_enable", ser_enable, 0);
        check("arst_count", fifo_count, 0);
        check("arst_busy", busy, 0);
        check("arst_wr_ready", wr_ready, 1);
        check("arst_underrun_cnt", underrun_count, 0);
        exp_q.delete();
        play = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'h6601;
        exp_q.push_back(16'h6601);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        check("first_push_count", fifo_count, 1);
        play_until(words_started + 1);
        check("final_count", fifo_count, 0);
        check("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
